linear_proj_ctrl: RTL and testbench
===================================

# linear_proj_ctrl

Sequencer for the linear-projection stage of multi-head attention. It walks every output tile of matrix C (row-major), and for each tile it streams the matching A and B block addresses over the inner dimension into the BRAM read ports. It marks the first and last beat for the multi-matmul array, waits for the tile result, then hands it downstream with a valid/ready handshake. It sits between the A/B weight/input BRAMs, the multi_matmul wrapper and the output writer, and raises done after the last tile.

## Interface
- ROW_SIZE_MAT_C, default 2: output tile rows (A-side groups).
- COL_SIZE_MAT_C, default 2: output tile columns (B-side groups).
- INNER_BLOCKS, default 3: inner-dimension beats per tile (INNER_DIMENSION/BLOCK_SIZE).
- ADDR_WIDTH_A, default 4: A BRAM address width; must hold ROW_SIZE_MAT_C*INNER_BLOCKS-1.
- ADDR_WIDTH_B, default 4: B BRAM address width; must hold COL_SIZE_MAT_C*INNER_BLOCKS-1.
- MAX_FLAG, default ROW_SIZE_MAT_C*COL_SIZE_MAT_C: tiles per run.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- mm_ready  in  1  matmul can accept a beat.
- mm_done  in  1  one-cycle pulse: accumulated tile available.
- out_ready  in  1  downstream accepts tile.
- en_a, en_b  out  1  BRAM read enables.
- addr_a  out  ADDR_WIDTH_A  A read address.
- addr_b  out  ADDR_WIDTH_B  B read address.
- mm_in_valid  out  1  BRAM data on bus is a valid beat.
- mm_first, mm_last  out  1  qualify first/last beat of a tile (only with mm_in_valid).
- out_valid  out  1  tile result ready for downstream.
- tile_row  out  $clog2(ROW_SIZE_MAT_C)+1  current tile row.
- tile_col  out  $clog2(COL_SIZE_MAT_C)+1  current tile column.
- flag_count  out  $clog2(MAX_FLAG)+1  tiles delivered this run.
- busy  out  1  high in every state but IDLE.
- done  out  1  one-cycle pulse at run end.
- protocol_err  out  1  sticky; mm_done outside WAIT_MM.

## Operation
- States: IDLE, FETCH, WAIT_MM, WRITE, DONE.
- IDLE: start=1 -> clear row, col, k, flag_count, protocol_err; go to FETCH.
- FETCH: when mm_ready=1, issue beat k: en_a=en_b=1, addr_a=row*INNER_BLOCKS+k, addr_b=col*INNER_BLOCKS+k; k++. When mm_ready=0, en low and addresses held. After the beat with k=INNER_BLOCKS-1 is issued, clear k and go to WAIT_MM.
- Beat qualifiers are delayed one cycle to match the 1-cycle BRAM latency. mm_in_valid=1 the cycle after an issue. mm_first=1 when the issued k was 0; mm_last=1 when it was INNER_BLOCKS-1. INNER_BLOCKS=1 gives first and last on the same beat.
- The matmul must accept a beat that arrives one cycle after it showed mm_ready=1.
- WAIT_MM: on mm_done go to WRITE. mm_done may arrive in the same cycle as the trailing mm_in_valid, or later.
- WRITE: out_valid=1 with stable tile_row/tile_col until out_ready=1. On the handshake, flag_count++, col++; on col wrap (col==COL_SIZE_MAT_C-1) col=0, row++. Next state is DONE if the new flag_count==MAX_FLAG, else FETCH.
- DONE: done=1 for one cycle, then IDLE. Counters keep their final values until the next start.
- start while busy is ignored. mm_done in IDLE/FETCH/WRITE/DONE is ignored and sets protocol_err.
- Arithmetic is unsigned. Address products are truncated to the address width; the parameter constraints guarantee no overflow.

## Timing
- All outputs are registered. Reset values are 0 for all outputs, and the state is IDLE.
- rst_n low takes effect immediately, mid-run included. In-flight beats are abandoned, and no mm_in_valid follows the release of reset.
- start at edge t -> first en_a at t+1 if mm_ready is high. Corresponding mm_in_valid/mm_first at t+2.
- Minimum tile period: INNER_BLOCKS issue cycles + matmul latency + 1 WRITE cycle + 1 cycle to re-enter FETCH.
- out_ready low stalls in WRITE indefinitely; no new fetch is issued.

## Test plan
- Default parameters, mm_ready=1, mm_done 2 cycles after each mm_last, out_ready=1 -> A addresses 0,1,2,0,1,2,3,4,5,3,4,5. B addresses 0,1,2,3,4,5,0,1,2,3,4,5. Tiles (0,0),(0,1),(1,0),(1,1). flag_count ends at 4 and done pulses once.
- mm_ready toggling 1,0,1,0 during FETCH -> en low and addresses held while mm_ready=0. Exactly 3 beats per tile, first and last flagged correctly.
- out_ready held low 5 cycles on tile (0,1) -> out_valid, tile_row=0, tile_col=1 stable. flag_count increments only on the handshake.
- start pulsed in WAIT_MM, and mm_done injected in FETCH -> run unaffected; protocol_err=1 until the next start.
- rst_n asserted mid-FETCH of tile (1,0) -> all outputs 0 asynchronously. A new start restarts at tile (0,0) with flag_count=0.
- INNER_BLOCKS=1, ROW=COL=1 -> a single beat with mm_first=mm_last=1, one tile, done pulse.

Source files
------------

// File: rtl/linear_proj_if.sv
// linear_proj_if
//   Bundles the sequencer's control, BRAM-read, matmul and downstream
//   signals so the controller and its environment share one connection.
//
//   master modport (the controller):
//     in : start, mm_ready, mm_done, out_ready
//     out: en_a, en_b, addr_a, addr_b, mm_in_valid, mm_first, mm_last,
//          out_valid, tile_row, tile_col, flag_count, busy, done,
//          protocol_err
//   slave modport: the same signals seen from the environment.
//
//   The width parameters must match the controller's derived widths:
//     ROW_W  = $clog2(ROW_SIZE_MAT_C)+1
//     COL_W  = $clog2(COL_SIZE_MAT_C)+1
//     FLAG_W = $clog2(MAX_FLAG)+1
interface linear_proj_if #(
    parameter int ADDR_WIDTH_A = 4,
    parameter int ADDR_WIDTH_B = 4,
    parameter int ROW_W        = 2,
    parameter int COL_W        = 2,
    parameter int FLAG_W       = 3
);
    logic                    start;
    logic                    mm_ready;
    logic                    mm_done;
    logic                    out_ready;
    logic                    en_a;
    logic                    en_b;
    logic [ADDR_WIDTH_A-1:0] addr_a;
    logic [ADDR_WIDTH_B-1:0] addr_b;
    logic                    mm_in_valid;
    logic                    mm_first;
    logic                    mm_last;
    logic                    out_valid;
    logic [ROW_W-1:0]        tile_row;
    logic [COL_W-1:0]        tile_col;
    logic [FLAG_W-1:0]       flag_count;
    logic                    busy;
    logic                    done;
    logic                    protocol_err;

    modport master (
        input  start, mm_ready, mm_done, out_ready,
        output en_a, en_b, addr_a, addr_b, mm_in_valid, mm_first, mm_last,
               out_valid, tile_row, tile_col, flag_count, busy, done,
               protocol_err
    );

    modport slave (
        output start, mm_ready, mm_done, out_ready,
        input  en_a, en_b, addr_a, addr_b, mm_in_valid, mm_first, mm_last,
               out_valid, tile_row, tile_col, flag_count, busy, done,
               protocol_err
    );
endinterface

// File: rtl/linear_proj_ctrl.sv
// linear_proj_ctrl
//   Sequencer for the linear-projection stage of multi-head attention.
//   Walks the output tiles of C in row-major order; for each tile it streams
//   the A/B block addresses over the inner dimension into the BRAM read
//   ports, tags the first/last beat for the matmul array (one cycle later,
//   aligned with BRAM read data), waits for the tile result and hands it
//   downstream with a valid/ready handshake. done pulses after the last tile.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    linear_proj_if.master (start/mm_ready/mm_done/out_ready in;
//            BRAM enables/addresses, beat qualifiers, tile position,
//            flag_count, busy, done, protocol_err out). All outputs are
//            registered.
module linear_proj_ctrl #(
    parameter int ROW_SIZE_MAT_C = 2,
    parameter int COL_SIZE_MAT_C = 2,
    parameter int INNER_BLOCKS   = 3,
    parameter int ADDR_WIDTH_A   = 4,
    parameter int ADDR_WIDTH_B   = 4,
    parameter int MAX_FLAG       = ROW_SIZE_MAT_C * COL_SIZE_MAT_C
) (
    input  logic          clk,
    input  logic          rst_n,
    linear_proj_if.master bus
);
    localparam int ROW_W  = $clog2(ROW_SIZE_MAT_C) + 1;
    localparam int COL_W  = $clog2(COL_SIZE_MAT_C) + 1;
    localparam int FLAG_W = $clog2(MAX_FLAG) + 1;
    localparam int K_W    = $clog2(INNER_BLOCKS) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MM, WRITE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [ROW_W-1:0]        row, row_nxt;
    logic [COL_W-1:0]        col, col_nxt;
    logic [K_W-1:0]          k, k_nxt;
    logic [FLAG_W-1:0]       flag_count, flag_nxt, flag_inc;
    logic                    prot_err, prot_err_nxt;
    logic                    out_valid, out_valid_nxt;
    logic                    done, done_nxt;
    logic                    busy;
    logic                    en_p0, en_p0_nxt;
    logic [ADDR_WIDTH_A-1:0] addr_a_p0, addr_a_p0_nxt;
    logic [ADDR_WIDTH_B-1:0] addr_b_p0, addr_b_p0_nxt;
    logic                    first_p0, first_p0_nxt;
    logic                    last_p0, last_p0_nxt;
    logic                    vld_p1, first_p1, last_p1;

    // Block address = group * INNER_BLOCKS + k; the parameter limits keep it
    // inside the address width, so the caller simply truncates.
    function automatic logic [31:0] blk_index(input logic [31:0] grp,
                                              input logic [31:0] kk);
        return grp * INNER_BLOCKS + kk;
    endfunction

    assign flag_inc = flag_count + FLAG_W'(1);

    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        col_nxt       = col;
        k_nxt         = k;
        flag_nxt      = flag_count;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        en_p0_nxt     = 1'b0;
        addr_a_p0_nxt = addr_a_p0;
        addr_b_p0_nxt = addr_b_p0;
        first_p0_nxt  = 1'b0;
        last_p0_nxt   = 1'b0;
        // mm_done is only meaningful while a tile result is awaited.
        prot_err_nxt  = prot_err | (bus.mm_done && (state != WAIT_MM));

        case (state)
            IDLE: begin
                if (bus.start) begin
                    row_nxt      = '0;
                    col_nxt      = '0;
                    k_nxt        = '0;
                    flag_nxt     = '0;
                    prot_err_nxt = bus.mm_done;
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                // Addresses only move on an issued beat, so they hold while
                // the matmul back-pressures.
                if (bus.mm_ready) begin
                    en_p0_nxt     = 1'b1;
                    addr_a_p0_nxt = ADDR_WIDTH_A'(blk_index(32'(row), 32'(k)));
                    addr_b_p0_nxt = ADDR_WIDTH_B'(blk_index(32'(col), 32'(k)));
                    first_p0_nxt  = (k == '0);
                    last_p0_nxt   = (k == K_W'(INNER_BLOCKS - 1));
                    if (k == K_W'(INNER_BLOCKS - 1)) begin
                        k_nxt     = '0;
                        state_nxt = WAIT_MM;
                    end else begin
                        k_nxt = k + K_W'(1);
                    end
                end
            end
            WAIT_MM: begin
                if (bus.mm_done) begin
                    out_valid_nxt = 1'b1;
                    state_nxt     = WRITE;
                end
            end
            WRITE: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    flag_nxt      = flag_inc;
                    if (col == COL_W'(COL_SIZE_MAT_C - 1)) begin
                        col_nxt = '0;
                        row_nxt = row + ROW_W'(1);
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                    if (flag_inc == FLAG_W'(MAX_FLAG)) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Every register, data included, resets so the whole output set reads 0
    // and no in-flight beat survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            k          <= '0;
            flag_count <= '0;
            prot_err   <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            en_p0      <= 1'b0;
            addr_a_p0  <= '0;
            addr_b_p0  <= '0;
            first_p0   <= 1'b0;
            last_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            first_p1   <= 1'b0;
            last_p1    <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            k          <= k_nxt;
            flag_count <= flag_nxt;
            prot_err   <= prot_err_nxt;
            out_valid  <= out_valid_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != IDLE);
            // p0: beat issue to the BRAM read ports
            en_p0      <= en_p0_nxt;
            addr_a_p0  <= addr_a_p0_nxt;
            addr_b_p0  <= addr_b_p0_nxt;
            first_p0   <= first_p0_nxt;
            last_p0    <= last_p0_nxt;
            // p1: qualifiers aligned with the BRAM read data
            vld_p1     <= en_p0;
            first_p1   <= en_p0 & first_p0;
            last_p1    <= en_p0 & last_p0;
        end
    end

    assign bus.en_a         = en_p0;
    assign bus.en_b         = en_p0;
    assign bus.addr_a       = addr_a_p0;
    assign bus.addr_b       = addr_b_p0;
    assign bus.mm_in_valid  = vld_p1;
    assign bus.mm_first     = first_p1;
    assign bus.mm_last      = last_p1;
    assign bus.out_valid    = out_valid;
    assign bus.tile_row     = row;
    assign bus.tile_col     = col;
    assign bus.flag_count   = flag_count;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.protocol_err = prot_err;
endmodule

// File: tb/tb_linear_proj_ctrl.sv
// Testbench for linear_proj_ctrl: default 2x2x3 instance checked through a
// scoreboard (expected beats/tiles queued by the stimulus, popped by a
// monitor), plus a 1x1x1 instance checked with directed cycle checks.
module tb_linear_proj_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linear_proj_if #(.ADDR_WIDTH_A(4), .ADDR_WIDTH_B(4), .ROW_W(2), .COL_W(2), .FLAG_W(3)) bus ();
    linear_proj_if #(.ADDR_WIDTH_A(4), .ADDR_WIDTH_B(4), .ROW_W(1), .COL_W(1), .FLAG_W(1)) bus2 ();

    linear_proj_ctrl #(
        .ROW_SIZE_MAT_C(2), .COL_SIZE_MAT_C(2), .INNER_BLOCKS(3),
        .ADDR_WIDTH_A(4), .ADDR_WIDTH_B(4)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    linear_proj_ctrl #(
        .ROW_SIZE_MAT_C(1), .COL_SIZE_MAT_C(1), .INNER_BLOCKS(1),
        .ADDR_WIDTH_A(4), .ADDR_WIDTH_B(4)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_addr[$];   // {addr_a, addr_b}
    logic [1:0] exp_flag[$];   // {mm_first, mm_last}
    logic [3:0] exp_tile[$];   // {tile_row, tile_col}

    int a_tab[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int b_tab[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int r_tab[4]  = '{0, 0, 1, 1};
    int c_tab[4]  = '{0, 1, 0, 1};

    logic mm_done_model = 1'b0;
    logic mm_done_inj   = 1'b0;
    logic toggle_mode   = 1'b0;
    int   stall_left    = 0;
    int   done_cnt      = 0;
    logic rdy_at_edge   = 1'b0;
    logic prev_valid    = 1'b0;
    logic [7:0] prev_ab = '0;
    logic [7:0] e8;
    logic [1:0] e2;
    logic [3:0] e4;

    assign bus.mm_done = mm_done_model | mm_done_inj;

    logic [23:0] outs_dut;
    logic [19:0] outs2;
    assign outs_dut = {bus.en_a, bus.en_b, bus.addr_a, bus.addr_b, bus.mm_in_valid,
                       bus.mm_first, bus.mm_last, bus.out_valid, bus.tile_row,
                       bus.tile_col, bus.flag_count, bus.busy, bus.done, bus.protocol_err};
    assign outs2 = {bus2.en_a, bus2.en_b, bus2.addr_a, bus2.addr_b, bus2.mm_in_valid,
                    bus2.mm_first, bus2.mm_last, bus2.out_valid, bus2.tile_row,
                    bus2.tile_col, bus2.flag_count, bus2.busy, bus2.done, bus2.protocol_err};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Matmul: mm_done pulse two cycles after the cycle carrying mm_last.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.mm_in_valid && bus.mm_last) begin
                @(posedge clk);
                @(posedge clk);
                #2 mm_done_model = 1'b1;
                @(posedge clk);
                #2 mm_done_model = 1'b0;
            end
        end
    end

    // mm_ready: constant 1, or toggling every cycle.
    initial begin
        bus.mm_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 bus.mm_ready = toggle_mode ? ~bus.mm_ready : 1'b1;
        end
    end

    // out_ready: low for stall_left cycles while tile (0,1) is offered.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_left > 0 && bus.out_valid && bus.tile_row == 2'd0 && bus.tile_col == 2'd1) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    always @(posedge clk) rdy_at_edge = bus.mm_ready;

    // Monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.en_a || bus.en_b) begin
                chk("en_pair", bus.en_a, bus.en_b);
                chk("en_needs_ready", rdy_at_edge, 1);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: addr_a=%0d addr_b=%0d, no beat required", bus.addr_a, bus.addr_b);
                end else begin
                    e8 = exp_addr.pop_front();
                    chk("addr_ab", {bus.addr_a, bus.addr_b}, e8);
                end
            end else if (prev_valid) begin
                chk("addr_hold", {bus.addr_a, bus.addr_b}, prev_ab);
            end
            prev_ab = {bus.addr_a, bus.addr_b};
            prev_valid = 1'b1;

            if (bus.mm_in_valid) begin
                if (exp_flag.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_unexpected: mm_in_valid=1, no beat required");
                end else begin
                    e2 = exp_flag.pop_front();
                    chk("first_last", {bus.mm_first, bus.mm_last}, e2);
                end
            end else begin
                chk("qual_idle", {bus.mm_first, bus.mm_last}, 0);
            end

            if (bus.out_valid && bus.out_ready) begin
                if (exp_tile.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tile_unexpected: row=%0d col=%0d", bus.tile_row, bus.tile_col);
                end else begin
                    e4 = exp_tile.pop_front();
                    chk("tile_pos", {bus.tile_row, bus.tile_col}, e4);
                end
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_hold", {bus.tile_row, bus.tile_col, bus.flag_count, bus.en_a},
                    {2'd0, 2'd1, 3'd1, 1'b0});
            if (bus.done) done_cnt++;
        end
    end

    task automatic push_run();
        for (int i = 0; i < 12; i++) begin
            exp_addr.push_back({4'(a_tab[i]), 4'(b_tab[i])});
            exp_flag.push_back({(i % 3) == 0, (i % 3) == 2});
        end
        for (int t = 0; t < 4; t++) exp_tile.push_back({2'(r_tab[t]), 2'(c_tab[t])});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_in_time"}, n < 400, 1);
        repeat (3) @(negedge clk);
        chk({name, "_flag_final"}, bus.flag_count, 4);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_queues_empty"}, exp_addr.size() + exp_flag.size() + exp_tile.size(), 0);
        chk({name, "_idle"}, {bus.busy, bus.out_valid, bus.en_a}, 0);
    endtask

    task automatic do_run(input string name);
        done_cnt = 0;
        push_run();
        pulse_start();
        finish_run(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus2.start = 1'b0;
        bus2.mm_ready = 1'b1;
        bus2.mm_done = 1'b0;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs_dut, 0);
        chk("reset_outputs_1x1", outs2, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", outs_dut, 0);

        // Plain run: addresses, qualifiers, tile order, done.
        do_run("basic");

        // Back-pressure from the matmul.
        toggle_mode = 1'b1;
        do_run("toggle");
        toggle_mode = 1'b0;

        // Downstream stall on tile (0,1).
        stall_left = 5;
        do_run("stall");
        chk("stall_cycles_used", stall_left, 0);

        // Stray start in WAIT_MM and stray mm_done in FETCH.
        done_cnt = 0;
        push_run();
        pulse_start();
        n = 0;
        while (!(bus.en_a && bus.addr_a == 4'd0 && bus.addr_b == 4'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("proto_first_beat_seen", n < 50, 1);
        mm_done_inj = 1'b1;
        @(posedge clk);
        #2 mm_done_inj = 1'b0;
        n = 0;
        while (!(bus.mm_in_valid && bus.mm_last) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("proto_last_beat_seen", n < 50, 1);
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        finish_run("proto");
        chk("proto_err_set", bus.protocol_err, 1);
        repeat (3) @(negedge clk);
        chk("proto_err_sticky", bus.protocol_err, 1);

        // Reset in the middle of tile (1,0), then a clean restart.
        push_run();
        pulse_start();
        @(negedge clk);
        chk("restart_clears_err", {bus.protocol_err, bus.flag_count}, 0);
        n = 0;
        while (!(bus.en_a && bus.addr_a == 4'd3 && bus.addr_b == 4'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tile10_fetch_seen", n < 100, 1);
        chk("tile10_position", {bus.tile_row, bus.tile_col, bus.flag_count}, {2'd1, 2'd0, 3'd2});
        #1 rst_n = 1'b0;
        exp_addr.delete();
        exp_flag.delete();
        exp_tile.delete();
        #1 chk("async_reset_outputs", outs_dut, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("quiet_after_reset", outs_dut, 0);
        do_run("restart");

        // 1x1 tile, single inner block.
        @(posedge clk);
        #2 bus2.start = 1'b1;
        @(posedge clk);
        #2 bus2.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("one_issue", {bus2.en_a, bus2.en_b, bus2.addr_a, bus2.addr_b, bus2.mm_in_valid}, {2'b11, 8'd0, 1'b0});
        @(negedge clk);
        chk("one_beat_qual", {bus2.mm_in_valid, bus2.mm_first, bus2.mm_last, bus2.en_a}, 4'b1110);
        bus2.mm_done = 1'b1;
        @(posedge clk);
        #2 bus2.mm_done = 1'b0;
        @(negedge clk);
        chk("one_out_valid", {bus2.out_valid, bus2.tile_row, bus2.tile_col, bus2.flag_count, bus2.done}, 5'b10000);
        @(negedge clk);
        chk("one_done", {bus2.done, bus2.flag_count, bus2.busy, bus2.out_valid}, 4'b1110);
        @(negedge clk);
        chk("one_idle", {bus2.done, bus2.busy, bus2.flag_count, bus2.protocol_err}, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
